// File: rtl/date_pkg.sv
// Shared calendar types, constants and BCD helpers for the date counter.
// Latency: none (functions and constants only).
// Backpressure: not applicable.
package date_pkg;

  localparam int YEAR_W = 16;

  localparam logic [3:0] MON_JAN = 4'd1;
  localparam logic [3:0] MON_FEB = 4'd2;
  localparam logic [3:0] MON_MAR = 4'd3;
  localparam logic [3:0] MON_APR = 4'd4;
  localparam logic [3:0] MON_MAY = 4'd5;
  localparam logic [3:0] MON_JUN = 4'd6;
  localparam logic [3:0] MON_JUL = 4'd7;
  localparam logic [3:0] MON_AUG = 4'd8;
  localparam logic [3:0] MON_SEP = 4'd9;
  localparam logic [3:0] MON_OCT = 4'd10;
  localparam logic [3:0] MON_NOV = 4'd11;
  localparam logic [3:0] MON_DEC = 4'd12;

  localparam logic [4:0] DAYS_30       = 5'd30;
  localparam logic [4:0] DAYS_31       = 5'd31;
  localparam logic [4:0] DAYS_FEB      = 5'd28;
  localparam logic [4:0] DAYS_FEB_LEAP = 5'd29;

  // Two BCD digits are divisible by 4 iff: even tens with ones in {0,4,8},
  // or odd tens with ones in {2,6}.
  function automatic logic bcd2_div4(input logic [3:0] tens, input logic [3:0] ones);
    logic r;
    if (tens[0] == 1'b0)
      r = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
    else
      r = (ones == 4'd2) || (ones == 4'd6);
    return r;
  endfunction

  // Gregorian leap test straight on the BCD digits: century years defer to
  // the thousands/hundreds pair.
  function automatic logic is_leap_bcd(input logic [YEAR_W-1:0] y);
    logic lo_zero;
    lo_zero = (y[7:0] == 8'h00);
    return (!lo_zero && bcd2_div4(y[7:4], y[3:0])) ||
           ( lo_zero && bcd2_div4(y[15:12], y[11:8]));
  endfunction

  // True when every nibble is a legal decimal digit.
  function automatic logic bcd_digits_ok(input logic [YEAR_W-1:0] y);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < YEAR_W/4; i++)
      if (y[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // BCD +1 across all digits; MSB of the result is the carry out of 9999.
  function automatic logic [YEAR_W:0] bcd_year_inc(input logic [YEAR_W-1:0] y);
    logic [YEAR_W-1:0] r;
    logic              c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < YEAR_W/4; i++) begin
      if (c) begin
        if (y[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = y[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/date_days_in_month.sv
// Number of days in a month given the month number and leap flag.
// Latency: combinational.
// Backpressure: not applicable; out-of-range months report 0 days.
module date_days_in_month
  import date_pkg::*;
(
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] days
);

  // Month-length lookup; 0 for an illegal month so no day can fit it.
  always_comb begin
    days = 5'd0;
    case (month)
      MON_JAN, MON_MAR, MON_MAY, MON_JUL,
      MON_AUG, MON_OCT, MON_DEC:          days = DAYS_31;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: days = DAYS_30;
      MON_FEB:                            days = leap ? DAYS_FEB_LEAP : DAYS_FEB;
      default:                            days = 5'd0;
    endcase
  end

endmodule

// File: rtl/date_counter.sv
// Calendar date counter: advances on midnight ticks, accepts validated loads.
// Latency: one cycle from day_tick/set_valid to updated date and pulses.
// Backpressure: none; every tick/load is consumed, a load overrides a tick.
// Optional weekday register enabled by `DATE_WEEKDAY_EN.
module date_counter
  import date_pkg::*;
#(
  parameter logic [YEAR_W-1:0] RESET_YEAR_BCD = 16'h2000,
  parameter logic [2:0]        RESET_WEEKDAY  = 3'd6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              day_tick,
  input  logic              set_valid,
  input  logic [5:0]        set_day,
  input  logic [3:0]        set_month,
  input  logic [YEAR_W-1:0] set_year,
  input  logic [2:0]        set_weekday,
  output logic [5:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [2:0]        weekday,
  output logic              leap,
  output logic              month_end,
  output logic              year_wrap,
  output logic              set_err
);

  logic [4:0]        cur_dim;
  logic [4:0]        set_dim;
  logic              set_leap;
  logic              set_ok;
  logic              wd_ok;
  logic              last_day;
  logic [YEAR_W-1:0] year_inc;
  logic              year_carry;

  assign leap     = is_leap_bcd(year);
  assign set_leap = is_leap_bcd(set_year);

  date_days_in_month u_cur_dim (
    .month (month),
    .leap  (leap),
    .days  (cur_dim)
  );

  date_days_in_month u_set_dim (
    .month (set_month),
    .leap  (set_leap),
    .days  (set_dim)
  );

  assign {year_carry, year_inc} = bcd_year_inc(year);
  assign last_day = (day >= {1'b0, cur_dim});

  // A load is validated entirely against its own year, not the current one.
  assign set_ok = bcd_digits_ok(set_year) &&
                  (set_month >= MON_JAN) && (set_month <= MON_DEC) &&
                  (set_day != 6'd0) && (set_day <= {1'b0, set_dim}) &&
                  wd_ok;

  // Date registers and single-cycle status pulses; a load always beats a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day       <= 6'd1;
      month     <= MON_JAN;
      year      <= RESET_YEAR_BCD;
      month_end <= 1'b0;
      year_wrap <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      month_end <= 1'b0;
      year_wrap <= 1'b0;
      set_err   <= 1'b0;
      if (set_valid) begin
        if (set_ok) begin
          day   <= set_day;
          month <= set_month;
          year  <= set_year;
        end else begin
          set_err <= 1'b1;
        end
      end else if (day_tick) begin
        if (!last_day) begin
          day <= day + 6'd1;
        end else begin
          day       <= 6'd1;
          month_end <= 1'b1;
          if (month == MON_DEC) begin
            month     <= MON_JAN;
            year      <= year_inc;
            year_wrap <= year_carry;
          end else begin
            month <= month + 4'd1;
          end
        end
      end
    end
  end

`ifdef DATE_WEEKDAY_EN
  logic [2:0] wd_q;

  assign wd_ok   = (set_weekday <= 3'd6);
  assign weekday = wd_q;

  // Weekday follows accepted ticks modulo 7 and takes the value of accepted loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= RESET_WEEKDAY;
    end else if (set_valid) begin
      if (set_ok) wd_q <= set_weekday;
    end else if (day_tick) begin
      wd_q <= (wd_q == 3'd6) ? 3'd0 : wd_q + 3'd1;
    end
  end
`else
  logic unused_wd;

  assign wd_ok     = 1'b1;
  assign weekday   = 3'd0;
  assign unused_wd = ^{set_weekday, RESET_WEEKDAY};
`endif

endmodule

// File: tb/tb_date_counter.sv
// Directed test for date_counter: rollovers, leap rules, load checks, reset.
// Latency: checks sampled 1 time unit after the clock edge.
// Backpressure: not applicable.
module tb_date_counter;

  logic        clk;
  logic        rst_n;
  logic        day_tick;
  logic        set_valid;
  logic [5:0]  set_day;
  logic [3:0]  set_month;
  logic [15:0] set_year;
  logic [2:0]  set_weekday;
  logic [5:0]  day;
  logic [3:0]  month;
  logic [15:0] year;
  logic [2:0]  weekday;
  logic        leap;
  logic        month_end;
  logic        year_wrap;
  logic        set_err;

  int n_chk;
  int n_pass;

  date_counter #(
    .RESET_YEAR_BCD (16'h2000),
    .RESET_WEEKDAY  (3'd6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .day_tick    (day_tick),
    .set_valid   (set_valid),
    .set_day     (set_day),
    .set_month   (set_month),
    .set_year    (set_year),
    .set_weekday (set_weekday),
    .day         (day),
    .month       (month),
    .year        (year),
    .weekday     (weekday),
    .leap        (leap),
    .month_end   (month_end),
    .year_wrap   (year_wrap),
    .set_err     (set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic chk_date(input string tag, input logic [5:0] d, input logic [3:0] m,
                          input logic [15:0] y);
    chk({tag, ".day"},   {26'd0, day},   {26'd0, d});
    chk({tag, ".month"}, {28'd0, month}, {28'd0, m});
    chk({tag, ".year"},  {16'd0, year},  {16'd0, y});
  endtask

  task automatic chk_pulses(input string tag, input logic me, input logic yw, input logic se);
    chk({tag, ".month_end"}, {31'd0, month_end}, {31'd0, me});
    chk({tag, ".year_wrap"}, {31'd0, year_wrap}, {31'd0, yw});
    chk({tag, ".set_err"},   {31'd0, set_err},   {31'd0, se});
  endtask

  // Present inputs for one edge, then return them to idle just after it.
  task automatic step(input logic tk, input logic sv, input logic [5:0] d,
                      input logic [3:0] m, input logic [15:0] y, input logic [2:0] w);
    day_tick    = tk;
    set_valid   = sv;
    set_day     = d;
    set_month   = m;
    set_year    = y;
    set_weekday = w;
    @(posedge clk);
    #1;
    day_tick  = 1'b0;
    set_valid = 1'b0;
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 6'd0, 4'd0, 16'h0000, 3'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 6'd0, 4'd0, 16'h0000, 3'd0);
  endtask

  task automatic load(input logic [5:0] d, input logic [3:0] m, input logic [15:0] y);
    step(1'b0, 1'b1, d, m, y, 3'd3);
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    day_tick    = 1'b0;
    set_valid   = 1'b0;
    set_day     = 6'd0;
    set_month   = 4'd0;
    set_year    = 16'h0000;
    set_weekday = 3'd0;
    repeat (2) @(posedge clk);
    #2;

    // Reset state
    chk_date("rst", 6'd1, 4'd1, 16'h2000);
    chk("rst.leap", {31'd0, leap}, 32'd1);
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);
`ifdef DATE_WEEKDAY_EN
    chk("rst.weekday", {29'd0, weekday}, 32'd6);
`else
    chk("rst.weekday", {29'd0, weekday}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First tick; weekday 6 wraps to 0 with the macro, stays 0 without
    tick();
    chk_date("t1", 6'd2, 4'd1, 16'h2000);
    chk("t1.weekday", {29'd0, weekday}, 32'd0);
    chk_pulses("t1", 1'b0, 1'b0, 1'b0);

    // 2023-02-28 -> 03-01
    load(6'd28, 4'd2, 16'h2023);
    chk_date("ld2023", 6'd28, 4'd2, 16'h2023);
    chk_pulses("ld2023", 1'b0, 1'b0, 1'b0);
    tick();
    chk_date("feb2023", 6'd1, 4'd3, 16'h2023);
    chk_pulses("feb2023", 1'b1, 1'b0, 1'b0);
    chk("feb2023.leap", {31'd0, leap}, 32'd0);
    idle();
    chk_pulses("feb2023.after", 1'b0, 1'b0, 1'b0);

    // 2024-02-28 -> 02-29 -> 03-01
    load(6'd28, 4'd2, 16'h2024);
    chk("ld2024.leap", {31'd0, leap}, 32'd1);
    tick();
    chk_date("feb2024", 6'd29, 4'd2, 16'h2024);
    chk_pulses("feb2024", 1'b0, 1'b0, 1'b0);
    tick();
    chk_date("feb2024b", 6'd1, 4'd3, 16'h2024);
    chk_pulses("feb2024b", 1'b1, 1'b0, 1'b0);

    // Century rules
    load(6'd28, 4'd2, 16'h2100);
    chk("ld2100.leap", {31'd0, leap}, 32'd0);
    tick();
    chk_date("feb2100", 6'd1, 4'd3, 16'h2100);
    load(6'd28, 4'd2, 16'h2000);
    tick();
    chk_date("feb2000", 6'd29, 4'd2, 16'h2000);
    chk("feb2000.leap", {31'd0, leap}, 32'd1);

    // Year carry through several digits
    load(6'd31, 4'd12, 16'h2099);
    tick();
    chk_date("ny2100", 6'd1, 4'd1, 16'h2100);
    chk_pulses("ny2100", 1'b1, 1'b0, 1'b0);

    // 9999 wrap
    load(6'd31, 4'd12, 16'h9999);
    tick();
    chk_date("wrap", 6'd1, 4'd1, 16'h0000);
    chk_pulses("wrap", 1'b1, 1'b1, 1'b0);
    chk("wrap.leap", {31'd0, leap}, 32'd1);
    idle();
    chk_pulses("wrap.after", 1'b0, 1'b0, 1'b0);

    // Rejected loads leave the date unchanged
    load(6'd29, 4'd2, 16'h2023);
    chk_pulses("bad_feb29", 1'b0, 1'b0, 1'b1);
    chk_date("bad_feb29", 6'd1, 4'd1, 16'h0000);
    load(6'd1, 4'd13, 16'h2023);
    chk_pulses("bad_mon13", 1'b0, 1'b0, 1'b1);
    load(6'd1, 4'd1, 16'h20A3);
    chk_pulses("bad_bcd", 1'b0, 1'b0, 1'b1);
    load(6'd0, 4'd1, 16'h2023);
    chk_pulses("bad_day0", 1'b0, 1'b0, 1'b1);
    load(6'd31, 4'd4, 16'h2023);
    chk_pulses("bad_apr31", 1'b0, 1'b0, 1'b1);
    chk_date("bad_all", 6'd1, 4'd1, 16'h0000);
    idle();
    chk_pulses("bad.after", 1'b0, 1'b0, 1'b0);

    // Accepted leap-day load
    load(6'd29, 4'd2, 16'h2024);
    chk_pulses("ok_feb29", 1'b0, 1'b0, 1'b0);
    chk_date("ok_feb29", 6'd29, 4'd2, 16'h2024);

    // Rejected load with a tick: tick is discarded too
    step(1'b1, 1'b1, 6'd29, 4'd2, 16'h2023, 3'd3);
    chk_pulses("badtick", 1'b0, 1'b0, 1'b1);
    chk_date("badtick", 6'd29, 4'd2, 16'h2024);

    // Back-to-back ticks across a 30-day month
    load(6'd29, 4'd4, 16'h2024);
    tick();
    chk_date("b2b1", 6'd30, 4'd4, 16'h2024);
    chk_pulses("b2b1", 1'b0, 1'b0, 1'b0);
    tick();
    chk_date("b2b2", 6'd1, 4'd5, 16'h2024);
    chk_pulses("b2b2", 1'b1, 1'b0, 1'b0);

    // Load wins over a simultaneous tick
    step(1'b1, 1'b1, 6'd15, 4'd6, 16'h2030, 3'd3);
    chk_date("ldtick", 6'd15, 4'd6, 16'h2030);
    chk_pulses("ldtick", 1'b0, 1'b0, 1'b0);

`ifdef DATE_WEEKDAY_EN
    step(1'b0, 1'b1, 6'd15, 4'd6, 16'h2030, 3'd7);
    chk_pulses("wd7", 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 6'd15, 4'd6, 16'h2030, 3'd6);
    chk("wd6", {29'd0, weekday}, 32'd6);
    tick();
    chk("wd_wrap", {29'd0, weekday}, 32'd0);
    chk_date("wd_wrap", 6'd16, 4'd6, 16'h2030);
`else
    step(1'b0, 1'b1, 6'd15, 4'd6, 16'h2030, 3'd7);
    chk_pulses("wd7_ignored", 1'b0, 1'b0, 1'b0);
    chk("wd_tied", {29'd0, weekday}, 32'd0);
`endif

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_date("arst", 6'd1, 4'd1, 16'h2000);
    chk_pulses("arst", 1'b0, 1'b0, 1'b0);
`ifdef DATE_WEEKDAY_EN
    chk("arst.weekday", {29'd0, weekday}, 32'd6);
`else
    chk("arst.weekday", {29'd0, weekday}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    chk_date("arst.after", 6'd1, 4'd1, 16'h2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
